// File: rtl/rom_axb_if.sv
// Read bus for the A x B product ROM: packed operand address, two read
// qualifiers and the registered product returned by the ROM.
interface rom_axb_if;
    logic [7:0] address;
    logic       read_one;
    logic       read_two;
    logic [7:0] data;

    modport master (
        output address,
        output read_one,
        output read_two,
        input  data
    );

    modport slave (
        input  address,
        input  read_one,
        input  read_two,
        output data
    );
endinterface

// File: rtl/rom_axb.sv
// 256 x 8 constant ROM holding the 4-bit x 4-bit unsigned multiplication table.
// Output is registered; a read needs both qualifiers high, otherwise it returns zero.
module rom_axb (
    input  logic      clk,
    input  logic      rst_n,
    rom_axb_if.slave  bus
);
    logic [7:0] w_rom [256];
    logic       w_rd;
    logic [7:0] r_data;

    // Each entry is a compile-time constant, so this folds into a plain lookup table.
    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_rom
            localparam logic [7:0] LP_A = 8'(gi / 16);
            localparam logic [7:0] LP_B = 8'(gi % 16);
            assign w_rom[gi] = LP_A * LP_B;
        end
    endgenerate

    assign w_rd = bus.read_one & bus.read_two;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 8'h00;
        end else if (w_rd) begin
            r_data <= w_rom[bus.address];
        end else begin
            r_data <= 8'h00;
        end
    end

    assign bus.data = r_data;
endmodule

// File: tb/tb_rom_axb.sv
// Self-checking bench for rom_axb: directed scenarios plus randomized reads
// compared against an arithmetic model of the multiplication table.
module tb_rom_axb;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rom_axb_if bus ();

    rom_axb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_data(input logic [7:0] addr, input logic r1, input logic r2);
        int a;
        int b;
        a = int'(addr) / 16;
        b = int'(addr) % 16;
        if (r1 && r2) return 8'(a * b);
        return 8'h00;
    endfunction

    task automatic drive(input logic [7:0] addr, input logic r1, input logic r2);
        bus.address  = addr;
        bus.read_one = r1;
        bus.read_two = r2;
    endtask

    // Advance one rising edge and move to the sampling point just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'hFF, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (bus.data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_initial: data=%02h expected=00", bus.data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.data !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_hold cycle %0d: data=%02h expected=00", i, bus.data);
            end
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.data !== 8'hE1) begin
            n_errors++;
            $display("FAIL reset_release: data=%02h expected=e1", bus.data);
        end
        $display("test_reset: address=ff first read data=%02h", bus.data);
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        for (int a = 0; a <= 8'h11; a++) begin
            drive(8'(a), 1'b1, 1'b1);
            exp = model_data(8'(a), 1'b1, 1'b1);
            step();
            n_checks++;
            if (bus.data !== exp) begin
                n_errors++;
                $display("FAIL sweep_read addr=%02h: data=%02h expected=%02h", a, bus.data, exp);
            end
            $display("sweep read addr=%02h data=%02h", a, bus.data);
            drive(8'($urandom_range(255)), 1'b0, 1'b0);
            step();
            n_checks++;
            if (bus.data !== 8'h00) begin
                n_errors++;
                $display("FAIL sweep_idle addr=%02h: data=%02h expected=00", a, bus.data);
            end
        end
    endtask

    task automatic test_spot();
        logic [7:0] addrs [6];
        logic [7:0] exps  [6];
        addrs = '{8'h34, 8'h77, 8'hF1, 8'h1F, 8'hFF, 8'hA5};
        exps  = '{8'h0C, 8'h31, 8'h0F, 8'h0F, 8'hE1, 8'h32};
        for (int i = 0; i < 6; i++) begin
            drive(addrs[i], 1'b1, 1'b1);
            step();
            n_checks++;
            if (bus.data !== exps[i]) begin
                n_errors++;
                $display("FAIL spot addr=%02h: data=%02h expected=%02h", addrs[i], bus.data, exps[i]);
            end
            $display("spot addr=%02h data=%02h", addrs[i], bus.data);
        end
    endtask

    task automatic test_qualifiers();
        logic [1:0] combos [3];
        combos = '{2'b10, 2'b01, 2'b00};
        drive(8'hFF, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(8'h23, combos[i][1], combos[i][0]);
            step();
            n_checks++;
            if (bus.data !== 8'h00) begin
                n_errors++;
                $display("FAIL qualifier r1=%0b r2=%0b: data=%02h expected=00",
                         combos[i][1], combos[i][0], bus.data);
            end
            $display("qualifier r1=%0b r2=%0b data=%02h", combos[i][1], combos[i][0], bus.data);
        end
        drive(8'h23, 1'b1, 1'b1);
        step();
        n_checks++;
        if (bus.data !== 8'h06) begin
            n_errors++;
            $display("FAIL qualifier_both: data=%02h expected=06", bus.data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [3];
        logic [7:0] exps  [3];
        addrs = '{8'h22, 8'h33, 8'h44};
        exps  = '{8'h04, 8'h09, 8'h10};
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], 1'b1, 1'b1);
            step();
            n_checks++;
            if (bus.data !== exps[i]) begin
                n_errors++;
                $display("FAIL stream addr=%02h: data=%02h expected=%02h", addrs[i], bus.data, exps[i]);
            end
            $display("stream addr=%02h data=%02h", addrs[i], bus.data);
        end
    endtask

    task automatic test_mid_reset();
        drive(8'h77, 1'b1, 1'b1);
        step();
        n_checks++;
        if (bus.data !== 8'h31) begin
            n_errors++;
            $display("FAIL midreset_pre: data=%02h expected=31", bus.data);
        end
        drive(8'h99, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.data !== 8'h00) begin
            n_errors++;
            $display("FAIL midreset_async: data=%02h expected=00", bus.data);
        end
        step();
        n_checks++;
        if (bus.data !== 8'h00) begin
            n_errors++;
            $display("FAIL midreset_held: data=%02h expected=00", bus.data);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.data !== 8'h51) begin
            n_errors++;
            $display("FAIL midreset_resume: data=%02h expected=51", bus.data);
        end
        $display("mid_reset resume addr=99 data=%02h", bus.data);
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic       r1;
        logic       r2;
        logic [7:0] exp;
        int         errs_before;
        errs_before = n_errors;
        for (int i = 0; i < 300; i++) begin
            a  = 8'($urandom_range(255));
            r1 = ($urandom_range(3) != 0);
            r2 = ($urandom_range(3) != 0);
            drive(a, r1, r2);
            exp = model_data(a, r1, r2);
            step();
            n_checks++;
            if (bus.data !== exp) begin
                n_errors++;
                $display("FAIL random #%0d addr=%02h r1=%0b r2=%0b: data=%02h expected=%02h",
                         i, a, r1, r2, bus.data, exp);
            end
        end
        $display("test_random: 300 reads, %0d errors", n_errors - errs_before);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_sweep();
        test_spot();
        test_qualifiers();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
